// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte stream (valid/ready) into the transmit buffer.
interface uart_tx_buffered_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: takes a byte when idle or on the last stop-bit cycle and shifts it out LSB first.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] byte_data,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  uart_tx_state_t       state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_done;

  assign bit_done   = (baud_cnt == CNT_LAST);
  // Taking the next byte on the last stop cycle gives zero-gap back-to-back frames.
  assign byte_ready = (state == IDLE) || ((state == STOP) && bit_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (byte_valid) begin
            shift <= byte_data;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
          if (bit_done) begin
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
          if (bit_done) begin
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
          if (bit_done) begin
            if (byte_valid) begin
              shift <= byte_data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: circular FIFO in front of an 8N1 serializer.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 32,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   s_if,
  output logic                tx,
  output logic                busy,
  output logic [CW-1:0]       fifo_count
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int AW  = CW - 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (CPB < 2)) begin : g_bad_params
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2 and CLKS_PER_BIT >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]        wr_ptr;
  logic [CW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 byte_ready;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[CW-1] != rd_ptr[CW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_if.s_ready = !full;
  assign push        = s_if.s_valid && !full;
  assign pop         = !empty && byte_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_if.s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .byte_data (mem[rd_ptr[AW-1:0]]),
    .byte_valid(!empty),
    .byte_ready(byte_ready),
    .tx        (tx),
    .busy      (busy)
  );

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued and matched against decoded frames.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = 10;
  localparam int CW         = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_if      (bus),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];
  bit         ok_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted byte is expected on the line, in order.
  always @(posedge clk) begin
    if (!rst && bus.s_valid === 1'b1 && bus.s_ready === 1'b1) exp_q.push_back(bus.s_data);
  end

  // Line monitor: decodes 8N1 frames by sampling mid-bit; frames cut by reset are dropped.
  logic [7:0] mon_b;
  bit         mon_ok;
  bit         mon_abort;
  int         mon_st;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_st = cyc;
        mon_ok = 1'b1;
        mon_abort = 1'b0;
        repeat (CPB / 2) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
        if (tx !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
          mon_b[i] = tx;
        end
        repeat (CPB) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
        if (tx !== 1'b1) mon_ok = 1'b0;
        if (!mon_abort) begin
          rx_q.push_back(mon_b);
          start_q.push_back(mon_st);
          ok_q.push_back(mon_ok);
        end
      end
    end
  end

  task automatic wait_rx(input int n, input int limit, output bit ok);
    int g = 0;
    while (rx_q.size() < n && g < limit) begin
      @(negedge clk);
      g++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.s_ready); end
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_idle();
    int bad_tx = 0, bad_busy = 0, bad_rdy = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (bus.s_ready !== 1'b1) bad_rdy++;
    end
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL idle_tx: %0d cycles not high, expected 0", bad_tx); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d cycles busy, expected 0", bad_busy); end
    n_checks++; if (bad_rdy != 0) begin n_fail++; $display("FAIL idle_ready: %0d cycles not ready, expected 0", bad_rdy); end
  endtask

  task automatic test_single();
    logic [7:0] b = 8'h55;
    logic       exp_tx;
    bit         got;
    logic [7:0] e, r;
    @(posedge clk); #1;
    bus.s_data = b; bus.s_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_after_push: got %b expected 1", tx); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_after_push: got %0d expected 1", fifo_count); end
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      exp_tx = (k < CPB) ? 1'b0 : (k < 9 * CPB) ? b[(k - CPB) / CPB] : 1'b1;
      n_checks++; if (tx !== exp_tx) begin n_fail++; $display("FAIL single_tx_cycle%0d: got %b expected %b", k, tx, exp_tx); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_cycle%0d: got %b expected 1", k, busy); end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_end: got %b expected 1", tx); end
    wait_rx(1, 50, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL single_rx_timeout: got 0 frames expected 1"); end
    if (got) begin
      r = rx_q.pop_front(); void'(start_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL single_data: got %02h expected %02h", r, e); end
      n_checks++; if (ok_q.pop_front() !== 1'b1) begin n_fail++; $display("FAIL single_framing: got bad expected good"); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3] = '{8'h41, 8'h42, 8'h43};
    int bc = 0;
    int s0, s1, s2;
    bit got;
    logic [7:0] e, r;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin bus.s_valid = 1'b1; bus.s_data = vals[k]; end
      else bus.s_valid = 1'b0;
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    n_checks++; if (bc != 300) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 300", bc); end
    wait_rx(3, 50, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL b2b_rx_timeout: got %0d frames expected 3", rx_q.size()); end
    if (got) begin
      s0 = start_q.pop_front(); s1 = start_q.pop_front(); s2 = start_q.pop_front();
      n_checks++; if (s1 - s0 != 100) begin n_fail++; $display("FAIL b2b_gap1: got %0d expected 100", s1 - s0); end
      n_checks++; if (s2 - s1 != 100) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected 100", s2 - s1); end
      for (int i = 0; i < 3; i++) begin
        r = rx_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (r !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %02h expected %02h", i, r, e); end
        n_checks++; if (ok_q.pop_front() !== 1'b1) begin n_fail++; $display("FAIL b2b_framing%0d: got bad expected good", i); end
      end
    end
  endtask

  task automatic test_fifo_full();
    int idx = 0, acc_before = 0, cnt_at_drop = -1, maxc = 0, g = 0;
    bit dropped = 0, rdy, got;
    logic [7:0] e, r;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    bus.s_data = 8'h00; bus.s_valid = 1'b1;
    while (idx < 10 && g < 3000) begin
      @(negedge clk); g++;
      rdy = bus.s_ready;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (!rdy && !dropped) begin dropped = 1; cnt_at_drop = int'(fifo_count); end
      if (rdy && !dropped) acc_before++;
      @(posedge clk); #1;
      if (rdy) begin idx++; bus.s_data = 8'(idx); end
    end
    bus.s_valid = 1'b0;
    n_checks++; if (idx != 10) begin n_fail++; $display("FAIL full_accepted: got %0d expected 10", idx); end
    n_checks++; if (acc_before != 5) begin n_fail++; $display("FAIL full_accept_before_drop: got %0d expected 5", acc_before); end
    n_checks++; if (cnt_at_drop != 4) begin n_fail++; $display("FAIL full_count_at_drop: got %0d expected 4", cnt_at_drop); end
    n_checks++; if (maxc > 4) begin n_fail++; $display("FAIL full_max_count: got %0d expected <=4", maxc); end
    wait_rx(10, 1500, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL full_rx_timeout: got %0d frames expected 10", rx_q.size()); end
    for (int i = 0; i < 10 && rx_q.size() > 0; i++) begin
      r = rx_q.pop_front(); void'(start_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (r !== e || r !== 8'(i)) begin n_fail++; $display("FAIL full_data%0d: got %02h expected %02h", i, r, 8'(i)); end
      n_checks++; if (ok_q.pop_front() !== 1'b1) begin n_fail++; $display("FAIL full_framing%0d: got bad expected good", i); end
    end
    repeat (150) @(negedge clk);
    n_checks++; if (rx_q.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL full_leftover: got rx=%0d exp=%0d expected 0/0", rx_q.size(), exp_q.size()); end
  endtask

  task automatic test_push_on_pop();
    bit got;
    logic [7:0] e, r;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 8'h10;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      bus.s_data = 8'(8'h10 + i);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_push_setup_count: got %0d expected 3", fifo_count); end
    repeat (97) @(posedge clk);
    #1; bus.s_valid = 1'b1; bus.s_data = 8'h14;
    @(negedge clk);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_push_before: got %0d expected 3", fifo_count); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL pop_push_stop_bit: got %b expected 1", tx); end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_push_after: got %0d expected 3", fifo_count); end
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL pop_push_next_start: got %b expected 0", tx); end
    wait_rx(5, 700, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL pop_push_rx_timeout: got %0d frames expected 5", rx_q.size()); end
    for (int i = 0; i < 5 && rx_q.size() > 0; i++) begin
      r = rx_q.pop_front(); void'(start_q.pop_front()); void'(ok_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (r !== e || r !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL pop_push_data%0d: got %02h expected %02h", i, r, 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad_tx = 0;
    bit got;
    logic [7:0] e, r;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    @(posedge clk); #1; bus.s_data = 8'h01;
    @(posedge clk); #1; bus.s_data = 8'h02;
    @(posedge clk); #1; bus.s_valid = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
    n_checks++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", bus.s_ready); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
    end
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL rstmid_quiet_line: %0d low cycles expected 0", bad_tx); end
    rx_q.delete(); start_q.delete(); ok_q.delete();
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 8'h3C;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_rx(1, 300, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL rstmid_rx_timeout: got 0 frames expected 1"); end
    if (got) begin
      r = rx_q.pop_front(); void'(start_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (r !== e || r !== 8'h3C) begin n_fail++; $display("FAIL rstmid_data: got %02h expected 3c", r); end
      n_checks++; if (ok_q.pop_front() !== 1'b1) begin n_fail++; $display("FAIL rstmid_framing: got bad expected good"); end
    end
    repeat (200) @(negedge clk);
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL rstmid_extra_frames: got %0d expected 0", rx_q.size()); end
    n_checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_final_idle: busy=%b count=%0d expected 0/0", busy, fifo_count); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_push_on_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
